rf_write_arbiter: RTL and testbench

- Shares the register file's single write port between two writeback sources.
- Source 0 is single-cycle ALU writeback. Source 1 is the multicycle/long-latency unit (multiplier, IO load).
- Keeps a pending-write scoreboard so decode can stall on reads of registers still owed a result by source 1.
- Drives the register file's write-enable, write-address and write-data inputs directly from registers.

---
 rtl/rf_write_arbiter_pkg.sv | 19 +
 rtl/rf_write_arbiter_rr.sv | 32 +++
 rtl/rf_write_arbiter.sv | 99 +++++++++
 tb/tb_rf_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: writeback source ids and request payload.
package rf_write_arbiter_pkg;

    localparam int unsigned RF_M    = 32;
    localparam int unsigned RF_N    = 8;
    localparam int unsigned RF_ADDR = $clog2(RF_M);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MC  = 1'b1
    } src_e;

    // Field widths follow the package defaults above.
    typedef struct packed {
        logic [RF_ADDR-1:0] rd;
        logic [RF_N-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Two-input round-robin arbiter; the source that lost (or sat out) the last grant wins a tie.
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    src_e last_grant;

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == SRC_MC) ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // A grant is always a transfer, so any valid request advances the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SRC_MC;
        end else if (|valid) begin
            last_grant <= grant[1] ? SRC_MC : SRC_ALU;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU and multicycle writeback,
// and tracks registers still owed a multicycle result so decode can stall.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter  int unsigned M      = RF_M,
    parameter  int unsigned N      = RF_N,
    localparam int unsigned AddrSz = $clog2(M)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [AddrSz-1:0] req0_rd,
    input  logic [N-1:0]      req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [AddrSz-1:0] req1_rd,
    input  logic [N-1:0]      req1_data,
    input  logic              issue_valid,
    input  logic [AddrSz-1:0] issue_rd,
    output logic              issue_err,
    input  logic [AddrSz-1:0] rs_chk,
    input  logic [AddrSz-1:0] rt_chk,
    output logic              hazard,
    output logic              rf_we,
    output logic [AddrSz-1:0] rf_wa,
    output logic [N-1:0]      rf_wd
);

    logic [1:0] grant;
    wb_req_t    req0;
    wb_req_t    req1;
    wb_req_t    win;
    src_e       wr_src;
    logic [M-1:0] pending;
    logic [M-1:0] pending_nxt;
    logic         err_nxt;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign req0.rd   = req0_rd;
    assign req0.data = req0_data;
    assign req1.rd   = req1_rd;
    assign req1.data = req1_data;
    assign win       = grant[1] ? req1 : req0;

    // Zero-register writes are accepted but never enabled onto the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            wr_src <= SRC_ALU;
        end else begin
            rf_we <= (|grant) && (win.rd != '0);
            if (|grant) begin
                rf_wa  <= win.rd;
                rf_wd  <= win.data;
                wr_src <= grant[1] ? SRC_MC : SRC_ALU;
            end
        end
    end

    // Clear from a committing multicycle write first so a same-edge issue wins.
    always_comb begin
        pending_nxt = pending;
        err_nxt     = 1'b0;
        if (rf_we && (wr_src == SRC_MC)) begin
            pending_nxt[rf_wa] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            err_nxt               = pending[issue_rd];
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            issue_err <= 1'b0;
        end else begin
            pending   <= pending_nxt;
            issue_err <= err_nxt;
        end
    end

    assign hazard = pending[rs_chk] | pending[rt_chk];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of grants, write stage and pending set.
module tb_rf_write_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, issue_valid;
    logic [4:0] req0_rd, req1_rd, issue_rd, rs_chk, rt_chk;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready, issue_err, hazard, rf_we;
    logic [4:0] rf_wa;
    logic [7:0] rf_wd;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit m_pend [32];
    int m_last;
    bit m_we;
    int m_wa, m_wd, m_src;
    bit m_err;

    rf_write_arbiter #(.M(32), .N(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_err   (issue_err),
        .rs_chk      (rs_chk),
        .rt_chk      (rt_chk),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
    );

    always #5 clk = ~clk;

    function automatic int exp_win();
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit exp_hazard();
        return m_pend[rs_chk] | m_pend[rt_chk];
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = 1;
        m_we = 1'b0; m_wa = 0; m_wd = 0; m_src = 0; m_err = 1'b0;
    endtask

    task automatic idle();
        req0_valid = 0; req0_rd = 0; req0_data = 0;
        req1_valid = 0; req1_rd = 0; req1_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    // Advance the model by one edge using the inputs currently driven, then cross the edge.
    task automatic clock_edge();
        int w;
        bit old [32];
        w = exp_win();
        old = m_pend;
        if (m_we && m_src == 1) m_pend[m_wa] = 1'b0;
        m_err = 1'b0;
        if (issue_valid && issue_rd != 0) begin
            m_err = old[issue_rd];
            m_pend[issue_rd] = 1'b1;
        end
        if (w >= 0) begin
            m_last = w;
            m_src  = w;
            m_wa   = (w == 0) ? int'(req0_rd) : int'(req1_rd);
            m_wd   = (w == 0) ? int'(req0_data) : int'(req1_data);
            m_we   = (m_wa != 0);
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rs_chk = 0; rt_chk = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_wa !== 5'd0) $display("FAIL reset_wa: got %0d want 0", rf_wa); else n_pass++;
        n_checks++; if (rf_wd !== 8'd0) $display("FAIL reset_wd: got %0h want 0", rf_wd); else n_pass++;
        n_checks++; if (issue_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", issue_err); else n_pass++;
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL reset_ready0: got %0b want 0", req0_ready); else n_pass++;
        n_checks++; if (req1_ready !== 1'b0) $display("FAIL reset_ready1: got %0b want 0", req1_ready); else n_pass++;
        for (int r = 0; r < 32; r++) begin
            rs_chk = 5'(r); rt_chk = 5'(31 - r);
            #1;
            n_checks++; if (hazard !== 1'b0) $display("FAIL reset_hazard r%0d: got %0b want 0", r, hazard); else n_pass++;
        end
        clock_edge();
    endtask

    task automatic test_single();
        idle();
        req0_valid = 1; req0_rd = 5; req0_data = 8'hA3;
        #1;
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL single_ready0: got %0b want 1", req0_ready); else n_pass++;
        n_checks++; if (req1_ready !== 1'b0) $display("FAIL single_ready1: got %0b want 0", req1_ready); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL single_we: got %0b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_wa !== 5'd5) $display("FAIL single_wa: got %0d want 5", rf_wa); else n_pass++;
        n_checks++; if (rf_wd !== 8'hA3) $display("FAIL single_wd: got %0h want a3", rf_wd); else n_pass++;
        clock_edge();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL single_we_drop: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_wa !== 5'd5) $display("FAIL single_wa_hold: got %0d want 5", rf_wa); else n_pass++;
    endtask

    task automatic test_back_to_back();
        idle();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        req0_valid = 1; req0_rd = 3; req0_data = 8'h30;
        req1_valid = 1; req1_rd = 7; req1_data = 8'h70;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (req0_ready !== (i % 2 == 0)) $display("FAIL b2b_ready0 c%0d: got %0b want %0b", i, req0_ready, (i % 2 == 0)); else n_pass++;
            n_checks++; if (req1_ready !== (i % 2 == 1)) $display("FAIL b2b_ready1 c%0d: got %0b want %0b", i, req1_ready, (i % 2 == 1)); else n_pass++;
            if (i > 0) begin
                n_checks++; if (rf_we !== 1'b1) $display("FAIL b2b_we c%0d: got %0b want 1", i, rf_we); else n_pass++;
                n_checks++; if (rf_wa !== ((i % 2 == 1) ? 5'd3 : 5'd7)) $display("FAIL b2b_wa c%0d: got %0d want %0d", i, rf_wa, (i % 2 == 1) ? 3 : 7); else n_pass++;
            end
            clock_edge();
        end
        idle();
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 8'h70) $display("FAIL b2b_last: got we=%0b wa=%0d wd=%0h want we=1 wa=7 wd=70", rf_we, rf_wa, rf_wd); else n_pass++;
        clock_edge();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL b2b_end_we: got %0b want 0", rf_we); else n_pass++;
    endtask

    task automatic test_scoreboard();
        idle();
        rs_chk = 9; rt_chk = 0;
        issue_valid = 1; issue_rd = 9;
        clock_edge();
        idle();
        #1;
        n_checks++; if (hazard !== 1'b1) $display("FAIL sb_hazard_set: got %0b want 1", hazard); else n_pass++;
        n_checks++; if (issue_err !== 1'b0) $display("FAIL sb_err_first: got %0b want 0", issue_err); else n_pass++;
        clock_edge();
        issue_valid = 1; issue_rd = 9;
        clock_edge();
        idle();
        #1;
        n_checks++; if (issue_err !== 1'b1) $display("FAIL sb_err_pulse: got %0b want 1", issue_err); else n_pass++;
        n_checks++; if (hazard !== 1'b1) $display("FAIL sb_hazard_hold: got %0b want 1", hazard); else n_pass++;
        clock_edge();
        n_checks++; if (issue_err !== 1'b0) $display("FAIL sb_err_clear: got %0b want 0", issue_err); else n_pass++;
        req1_valid = 1; req1_rd = 9; req1_data = 8'h55;
        #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL sb_ready1: got %0b want 1", req1_ready); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 8'h55) $display("FAIL sb_commit: got we=%0b wa=%0d wd=%0h want we=1 wa=9 wd=55", rf_we, rf_wa, rf_wd); else n_pass++;
        n_checks++; if (hazard !== 1'b1) $display("FAIL sb_hazard_commit_cycle: got %0b want 1", hazard); else n_pass++;
        clock_edge();
        n_checks++; if (hazard !== 1'b0) $display("FAIL sb_hazard_fall: got %0b want 0", hazard); else n_pass++;
    endtask

    task automatic test_same_edge();
        idle();
        rs_chk = 4; rt_chk = 0;
        issue_valid = 1; issue_rd = 4;
        clock_edge();
        idle();
        req1_valid = 1; req1_rd = 4; req1_data = 8'h66;
        clock_edge();
        idle();
        issue_valid = 1; issue_rd = 4;
        #1;
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4) $display("FAIL same_commit: got we=%0b wa=%0d want we=1 wa=4", rf_we, rf_wa); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_checks++; if (hazard !== 1'b1) $display("FAIL same_hazard: got %0b want 1", hazard); else n_pass++;
        n_checks++; if (issue_err !== 1'b1) $display("FAIL same_err: got %0b want 1", issue_err); else n_pass++;
        clock_edge();
        n_checks++; if (hazard !== 1'b1) $display("FAIL same_hazard_later: got %0b want 1", hazard); else n_pass++;
    endtask

    task automatic test_zero_and_reset();
        idle();
        rs_chk = 12; rt_chk = 0;
        req1_valid = 1; req1_rd = 0; req1_data = 8'h11;
        #1;
        n_checks++; if (req1_ready !== 1'b1) $display("FAIL zero_ready1: got %0b want 1", req1_ready); else n_pass++;
        clock_edge();
        idle();
        issue_valid = 1; issue_rd = 12;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL zero_we: got %0b want 0", rf_we); else n_pass++;
        clock_edge();
        idle();
        req0_valid = 1; req0_rd = 6; req0_data = 8'h3C;
        #1;
        n_checks++; if (hazard !== 1'b1) $display("FAIL rst_pre_hazard: got %0b want 1", hazard); else n_pass++;
        clock_edge();
        idle();
        #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL rst_pre_we: got %0b want 1", rf_we); else n_pass++;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL rst_mid_we: got %0b want 0", rf_we); else n_pass++;
        n_checks++; if (hazard !== 1'b0) $display("FAIL rst_mid_hazard: got %0b want 0", hazard); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            req0_valid  = ($urandom_range(0, 3) != 0);
            req1_valid  = ((c / 50) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            req0_rd     = 5'($urandom_range(0, 7));
            req1_rd     = 5'($urandom_range(0, 7));
            req0_data   = 8'($urandom);
            req1_data   = 8'($urandom);
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs_chk      = 5'($urandom_range(0, 7));
            rt_chk      = 5'($urandom_range(0, 7));
            #1;
            n_checks++; if (req0_ready !== (exp_win() == 0)) $display("FAIL rnd_ready0 c%0d: got %0b want %0b", c, req0_ready, (exp_win() == 0)); else n_pass++;
            n_checks++; if (req1_ready !== (exp_win() == 1)) $display("FAIL rnd_ready1 c%0d: got %0b want %0b", c, req1_ready, (exp_win() == 1)); else n_pass++;
            n_checks++; if (hazard !== exp_hazard()) $display("FAIL rnd_hazard c%0d: got %0b want %0b", c, hazard, exp_hazard()); else n_pass++;
            n_checks++; if (rf_we !== m_we) $display("FAIL rnd_we c%0d: got %0b want %0b", c, rf_we, m_we); else n_pass++;
            n_checks++; if (issue_err !== m_err) $display("FAIL rnd_err c%0d: got %0b want %0b", c, issue_err, m_err); else n_pass++;
            if (m_we) begin
                n_checks++; if (int'(rf_wa) != m_wa || int'(rf_wd) != m_wd) $display("FAIL rnd_wr c%0d: got wa=%0d wd=%0h want wa=%0d wd=%0h", c, rf_wa, rf_wd, m_wa, m_wd); else n_pass++;
            end
            clock_edge();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs_chk = 0; rt_chk = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_scoreboard();
        test_same_edge();
        test_zero_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
